cacheline_adapter: RTL and testbench
====================================

# cacheline_adapter

Converts the cache's 256-bit line-granular memory port (dfp_*) into 4-beat 64-bit bursts on the burst memory port (bmem_*). It sits directly downstream of the cache, between the cache's dfp side and the burst memory model. Line reads are assembled beat by beat into a 256-bit buffer; line writebacks are serialised into four 64-bit beats. Exactly one transaction is outstanding at a time.

## Interface
- LINE_W, 256: cache line width; must equal BEAT_W*BEATS.
- BEAT_W, 64: burst beat width.
- BEATS, 4: beats per line. The beat counter is log2(BEATS) bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dfp_addr  in  32  line address from the cache; bits [4:0] ignored.
- dfp_read  in  1  level request; held by the cache until dfp_resp.
- dfp_write  in  1  level request; held by the cache until dfp_resp.
- dfp_wdata  in  256  writeback line; beat i = bits [64i+63:64i].
- dfp_rdata  out  256  assembled read line; valid while dfp_resp=1.
- dfp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  32  {latched dfp_addr[31:5], 5'b0}.
- bmem_read  out  1  read burst request.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  64  current write beat.
- bmem_ready  in  1  memory accepts a request or beat this cycle.
- bmem_raddr  in  32  address tag of the returning beat.
- bmem_rdata  in  64  returning read beat.
- bmem_rvalid  in  1  bmem_rdata valid this cycle.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR, RESP.
- IDLE: latch the address on a request. dfp_write goes to WR and dfp_read goes to RD_REQ. If both are high, write wins; the cache never does this legally. Beat count resets to 0.
- RD_REQ: bmem_read=1 and bmem_addr=latched address. Advance to RD_DATA on the edge where bmem_ready=1.
- RD_DATA: each cycle with bmem_rvalid=1 and bmem_raddr==latched address, store bmem_rdata into buffer slice [count] and increment count. Beats may be non-consecutive. Go to RESP after beat BEATS-1 is stored.
- Beats with a mismatched raddr, or arriving in any other state, are dropped.
- WR: latch dfp_wdata into the line buffer on IDLE exit. Drive bmem_write=1, bmem_wdata=buffer slice [count], bmem_addr=latched address. Increment count on each edge with bmem_ready=1. Go to RESP after beat BEATS-1 is accepted.
- RESP: dfp_resp=1 for exactly one cycle; dfp_rdata=buffer. Then return to IDLE.
- dfp_rdata is driven from the buffer in all states, but is meaningful only in RESP.
- The buffer is shared by reads and writes.
- The count wraps to 0 on the transition into RESP.
- Address latching: bmem_addr holds constant for the whole transaction, independent of later changes on dfp_addr.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, count=0, buffer=0. dfp_resp, bmem_read and bmem_write are 0; bmem_addr=0; bmem_wdata=0.
- Reset mid-transaction aborts immediately. Memory beats still in flight are dropped by the state/raddr filter.
- Request in IDLE at cycle T: bmem_read or bmem_write is first high at T+1.
- Read, ideal memory (ready at T+1, beats at T+k..T+k+3): dfp_resp at T+k+4.
- Write, ready always 1: beats at T+1..T+4, dfp_resp at T+5.
- The cache still holds its request during the RESP cycle. The FSM is in IDLE at the next cycle, when the cache has dropped or changed the request, so no duplicate transaction is issued.
- Back-to-back requests are allowed: resp for a write at T, then dfp_read seen in IDLE at T+1.
- bmem_ready=0 stalls: request and beat outputs hold their values, and count does not advance.
- All outputs are registered-state decodes. There is no combinational path from dfp_* to bmem_*.

## Test plan
- Read, zero-stall: dfp_read, addr 0x1234_5678, memory returns beats 0x0..0/0x1..1/0x2..2/0x3..3 back-to-back. Required: bmem_addr=0x1234_5660; dfp_rdata={0x3..3,0x2..2,0x1..1,0x0..0}; dfp_resp high exactly 1 cycle.
- Write with stalls: dfp_write, wdata=0xDDDD..CCCC..BBBB..AAAA, bmem_ready toggling 1,0,1,0... Required: beats appear in order AAAA, BBBB, CCCC, DDDD, each held through stalls. Exactly 4 accepted beats, then dfp_resp.
- Gapped read: rvalid with gaps of 0–3 cycles, plus one beat with a wrong raddr. Required: the wrong-raddr beat is ignored and the line is assembled from the 4 matching beats only.
- Writeback then allocate: dfp_write acknowledged, dfp_read on the next cycle at a different address. Required: 4 write beats, then one bmem_read at the new address. No second write is issued.
- Reset mid-read: rst low after 2 beats, released, then a new read issued. Required: all outputs 0 during reset; stale beats are dropped; the new line is correct.
- Simultaneous dfp_read and dfp_write: the write burst is performed and no bmem_read is issued.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
// Line-side (dfp) and burst-side (bmem) bundles for the cache line adapter.
interface dfp_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface

interface bmem_if #(
  parameter int BEAT_W = 64
);
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Bridges 256-bit cache line requests to 4-beat 64-bit memory bursts.
// One transaction in flight; a shared line buffer serves reads and writes.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic   clk,
  input  logic   rst,
  dfp_if.slave   dfp,
  bmem_if.master bmem
);

  localparam int CW = $clog2(BEATS);
  localparam int OW = $clog2(LINE_W);
  localparam int SH = $clog2(BEAT_W);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [26:0]       addr_q, addr_d;

  logic [OW-1:0] off;
  logic          last;
  logic          hit;

  assign off  = OW'(cnt_q) << SH;
  assign last = cnt_q == CW'(BEATS - 1);
  // Only beats tagged with our own line address count.
  assign hit  = bmem.bmem_rvalid &&
                (bmem.bmem_raddr == {addr_q, 5'b0});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dfp.dfp_write) begin
          addr_d  = dfp.dfp_addr[31:5];
          buf_d   = dfp.dfp_wdata;
          state_d = WR;
        end else if (dfp.dfp_read) begin
          addr_d  = dfp.dfp_addr[31:5];
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (bmem.bmem_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (hit) begin
          buf_d[off +: BEAT_W] = bmem.bmem_rdata;
          if (last) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR: begin
        if (bmem.bmem_ready) begin
          if (last) begin
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  assign bmem.bmem_addr  = {addr_q, 5'b0};
  assign bmem.bmem_read  = state_q == RD_REQ;
  assign bmem.bmem_write = state_q == WR;
  assign bmem.bmem_wdata = buf_q[off +: BEAT_W];
  assign dfp.dfp_rdata   = buf_q;
  assign dfp.dfp_resp    = state_q == RESP;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized bench: a line/beat memory model drives the adapter and
// checks bursts, assembled lines and response timing.
module tb_cacheline_adapter;

  logic clk = 1'b0;
  logic rst;

  int n_chk  = 0;
  int n_pass = 0;

  dfp_if  #(.LINE_W(256)) dfp ();
  bmem_if #(.BEAT_W(64))  bmem ();

  cacheline_adapter #(
    .LINE_W(256),
    .BEAT_W(64),
    .BEATS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dfp (dfp),
    .bmem(bmem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [255:0] rline();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] beat(input logic [255:0] l,
                                       input int i);
    return l[i*64 +: 64];
  endfunction

  task automatic idle();
    @(negedge clk);
    chk("idle_resp", dfp.dfp_resp, 0);
    chk("idle_rd", bmem.bmem_read, 0);
    chk("idle_wr", bmem.bmem_write, 0);
  endtask

  // Ends on the negedge of the response cycle with the request dropped.
  task automatic do_read(input logic [31:0] a,
                         input logic [255:0] line,
                         input int lat, input int stall,
                         input int gapmax, input bit bad);
    logic [31:0] ea;
    int k, g, ns;
    ea = {a[31:5], 5'b0};
    dfp.dfp_read  = 1'b1;
    dfp.dfp_write = 1'b0;
    dfp.dfp_addr  = a;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!bmem.bmem_read)
        chk("rd_no_wr", bmem.bmem_write, 0);
    end while (!bmem.bmem_read && k < 6);
    chk("rd_lat", k, lat);
    chk("rd_addr", bmem.bmem_addr, ea);
    dfp.dfp_addr = $urandom;
    ns = $urandom_range(0, stall);
    for (int s = 0; s < ns; s++) begin
      // A tagged beat before the request is accepted must be dropped.
      bmem.bmem_ready  = 1'b0;
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = ea;
      bmem.bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      chk("rd_hold", bmem.bmem_read, 1);
      chk("rd_addr_hold", bmem.bmem_addr, ea);
    end
    bmem.bmem_ready  = 1'b1;
    bmem.bmem_rvalid = 1'b0;
    @(negedge clk);
    bmem.bmem_ready = 1'b0;
    chk("rd_req_drop", bmem.bmem_read, 0);
    for (int i = 0; i < 4; i++) begin
      g = $urandom_range(0, gapmax);
      if (bad && i == 1 && g == 0) g = 1;
      for (int j = 0; j < g; j++) begin
        bmem.bmem_rvalid = bad && i == 1 && j == 0;
        bmem.bmem_raddr  = ea ^ 32'h100;
        bmem.bmem_rdata  = {$urandom, $urandom};
        @(negedge clk);
        chk("rd_early", dfp.dfp_resp, 0);
      end
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = ea;
      bmem.bmem_rdata  = beat(line, i);
      @(negedge clk);
      bmem.bmem_rvalid = 1'b0;
      if (i < 3) chk("rd_early", dfp.dfp_resp, 0);
    end
    chk("rd_resp", dfp.dfp_resp, 1);
    chk("rd_line", dfp.dfp_rdata, line);
    chk("rd_addr_end", bmem.bmem_addr, ea);
    dfp.dfp_read = 1'b0;
  endtask

  // mode 0: ready toggles 1,0,..; 1: always ready; 2: random.
  task automatic do_write(input logic [31:0] a,
                          input logic [255:0] line,
                          input int mode, input bit both);
    logic [31:0] ea;
    int k, n;
    ea = {a[31:5], 5'b0};
    dfp.dfp_write = 1'b1;
    dfp.dfp_read  = both;
    dfp.dfp_addr  = a;
    dfp.dfp_wdata = line;
    k = 0;
    n = 0;
    forever begin
      @(negedge clk);
      k++;
      if (dfp.dfp_resp || k > 40) break;
      dfp.dfp_addr  = $urandom;
      dfp.dfp_wdata = rline();
      chk("wr_valid", bmem.bmem_write, 1);
      chk("wr_no_rd", bmem.bmem_read, 0);
      chk("wr_addr", bmem.bmem_addr, ea);
      if (n < 4) chk("wr_data", bmem.bmem_wdata, beat(line, n));
      else chk("wr_extra", n, 3);
      case (mode)
        0:       bmem.bmem_ready = k[0];
        1:       bmem.bmem_ready = 1'b1;
        default: bmem.bmem_ready = 1'($urandom);
      endcase
      if (bmem.bmem_ready) n++;
    end
    chk("wr_resp", dfp.dfp_resp, 1);
    chk("wr_beats", n, 4);
    if (mode == 1) chk("wr_lat", k, 5);
    bmem.bmem_ready = 1'b0;
    dfp.dfp_write   = 1'b0;
    dfp.dfp_read    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_resp"}, dfp.dfp_resp, 0);
    chk({tag, "_rd"}, bmem.bmem_read, 0);
    chk({tag, "_wr"}, bmem.bmem_write, 0);
    chk({tag, "_addr"}, bmem.bmem_addr, 0);
    chk({tag, "_wdata"}, bmem.bmem_wdata, 0);
    chk({tag, "_rdata"}, dfp.dfp_rdata, 0);
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    logic [31:0]  ea;
    rst = 1'b0;
    dfp.dfp_addr     = '0;
    dfp.dfp_read     = 1'b0;
    dfp.dfp_write    = 1'b0;
    dfp.dfp_wdata    = '0;
    bmem.bmem_ready  = 1'b0;
    bmem.bmem_raddr  = '0;
    bmem.bmem_rdata  = '0;
    bmem.bmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst = 1'b1;
    idle();

    l = {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}};
    do_read(32'h1234_5678, l, 1, 0, 0, 0);
    chk("rd_align", bmem.bmem_addr, 32'h1234_5660);
    idle();

    l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    do_write(32'h0000_1040, l, 0, 0);
    idle();

    do_write($urandom, rline(), 1, 0);
    idle();

    do_read($urandom, rline(), 1, 2, 3, 1);
    idle();

    do_write(32'hAAAA_0020, rline(), 2, 0);
    do_read(32'h5555_0040, rline(), 2, 1, 1, 0);
    idle();

    a  = 32'h0BAD_F00D;
    ea = {a[31:5], 5'b0};
    dfp.dfp_read = 1'b1;
    dfp.dfp_addr = a;
    @(negedge clk);
    bmem.bmem_ready = 1'b1;
    @(negedge clk);
    bmem.bmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem.bmem_rvalid = 1'b1;
      bmem.bmem_raddr  = ea;
      bmem.bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk_zero("mid_rst");
    dfp.dfp_read = 1'b0;
    @(negedge clk);
    chk_zero("in_rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bmem.bmem_rvalid = 1'b0;
    chk("post_rst_rd", bmem.bmem_read, 0);
    do_read(a, rline(), 1, 1, 2, 0);
    idle();

    do_write(32'h7777_7700, rline(), 2, 1);
    idle();

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, rline(), $urandom_range(0, 2), 0);
      else
        do_read($urandom, rline(), 1, 3, 3, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
      else do_read($urandom, rline(), 2, 2, 2, 0);
      idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
